// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch stage.
// A PC generator issues requests to an in-order, variable-latency instruction
// memory under a credit limit. Responses are collected in a small fetch queue
// that decode drains with a valid/ready handshake. A taken branch redirects
// both the request PC and the response PC, empties the queue and marks every
// request still in flight as stale so that its response is thrown away.

module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            freeze,
    input  logic            brTaken,
    input  logic [XLEN-1:0] brPC,
    input  logic [XLEN-1:0] brOffset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    // Queue pointers address QDEPTH (a power of two) entries and wrap freely;
    // the counters need one extra bit so they can hold the value QDEPTH.
    localparam int unsigned     PTRW     = $clog2(QDEPTH);
    localparam int unsigned     CW       = PTRW + 1;
    localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;  // address of next request
    logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;    // PC tagged on next kept response
    logic [CW-1:0]   count_q,    count_d;     // valid queue entries
    logic [CW-1:0]   outst_q,    outst_d;     // requests accepted, not answered
    logic [CW-1:0]   drop_q,     drop_d;      // stale responses still to discard
    logic [PTRW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q,   rd_ptr_d;

    // Queue storage (pc, instruction) per entry
    logic [XLEN-1:0] q_pc_q    [QDEPTH];
    logic [XLEN-1:0] q_instr_q [QDEPTH];
    logic [QDEPTH-1:0] wr_en;

    // Handshake / control terms
    logic            credit_ok;
    logic            req_fire;
    logic            head_valid;
    logic            pop;
    logic            rsp_drop;
    logic            push;
    logic [XLEN-1:0] br_target;

    // A request may only be issued when every in-flight response plus every
    // buffered instruction still fits in the queue; this is what guarantees
    // a response can always be accepted without back-pressure.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, count_q}) < {1'b0, QDEPTH_C};

    assign imem_req_valid = rstn && !freeze && !brTaken && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // The head is hidden during a redirect cycle so no pop can happen while
    // the queue is being flushed.
    assign head_valid = (count_q != '0);
    assign out_valid  = rstn && head_valid && !brTaken;
    assign pop        = out_valid && out_ready;

    // Responses that belong to requests issued before a redirect are stale.
    // A response arriving in the redirect cycle itself is never pushed.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign push     = imem_rsp_valid && !rsp_drop && !brTaken;

    // Branch target: word offset scaled to bytes, wrapping mod 2^XLEN.
    assign br_target = brPC + (brOffset << 2);

    // Head of queue is presented straight from the registered entries, so
    // outputs depend only on state, never on the memory response inputs.
    assign out_pc    = (rstn && head_valid) ? q_pc_q[rd_ptr_q]    : '0;
    assign out_instr = (rstn && head_valid) ? q_instr_q[rd_ptr_q] : '0;

    // Next-state computation for PCs, pointers and counters.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (brTaken) begin
            // Redirect: restart both PCs at the target and empty the queue.
            // No request is issued this cycle, so everything still in flight
            // after this cycle's response is retired must be discarded.
            fetch_pc_d = br_target;
            rsp_pc_d   = br_target;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            outst_d    = outst_q - CW'(imem_rsp_valid);
            drop_d     = outst_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Per-entry storage: an entry is written when a kept response targets it.
    // Entries need no reset because the outputs are masked by the count.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push && (wr_ptr_q == PTRW'(gi));

            // Capture the tagged response into this entry.
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    q_pc_q[gi]    <= rsp_pc_q;
                    q_instr_q[gi] <= imem_rsp_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural in-order
// instruction memory of configurable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        freeze = 1'b0;
    logic        brTaken = 1'b0;
    logic [31:0] brPC = '0;
    logic [31:0] brOffset = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .freeze         (freeze),
        .brTaken        (brTaken),
        .brPC           (brPC),
        .brOffset       (brOffset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cyc = 0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_in[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: sample handshakes before the edge, then update the
    // memory model and drive the next response after the edge.
    task automatic tick();
        logic        fire;
        logic        popv;
        logic [31:0] a;
        logic [31:0] ppc;
        logic [31:0] pin;
        #1;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        popv = out_valid && out_ready;
        ppc  = out_pc;
        pin  = out_instr;
        @(posedge clk);
        #1;
        if (!rstn) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (fire) begin
                mq_addr.push_back(a);
                mq_due.push_back(cyc + lat);
                req_log.push_back(a);
            end
            if (popv) begin
                pop_pc.push_back(ppc);
                pop_in.push_back(pin);
            end
        end
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rstn && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    endtask

    task automatic do_reset(input int l);
        rstn    = 1'b0;
        brTaken = 1'b0;
        freeze  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        lat = l;
        req_log.delete();
        pop_pc.delete();
        pop_in.delete();
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);

        // ---------------- streaming, 1-cycle memory ----------------
        do_reset(1);
        check("s_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("s_first_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 10; i++) tick();
        check("s_req1", req_log[1], 32'h104);
        check("s_req3", req_log[3], 32'h10C);
        check("s_pop_count", 32'(pop_pc.size()), 32'd8);
        check("s_pop0_pc", pop_pc[0], 32'h100);
        check("s_pop3_instr", pop_in[3], mem_word(32'h10C));
        check("s_pop7_pc", pop_pc[7], 32'h11C);

        // ---------------- decode stalled: credit limit ----------------
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("bp_req_count", 32'(req_log.size()), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_count", 32'(dut.count_q), 32'd4);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("bp_pop0", pop_pc[0], 32'h100);
        check("bp_pop1", pop_pc[1], 32'h104);
        check("bp_pop3_instr", pop_in[3], mem_word(32'h10C));
        check("bp_pop4", pop_pc[4], 32'h110);
        check("bp_req4", req_log[4], 32'h110);

        // ---------------- redirect with 3 requests in flight ----------------
        do_reset(4);
        for (int i = 0; i < 3; i++) tick();
        brTaken  = 1'b1;
        brPC     = 32'h200;
        brOffset = 32'hFFFF_FFFE;
        #1;
        check("br_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        brTaken = 1'b0;
        #1;
        check("br_drop", 32'(dut.drop_q), 32'd3);
        check("br_req_valid", 32'(imem_req_valid), 32'd1);
        check("br_req_addr", imem_req_addr, 32'h1F8);
        for (int i = 0; i < 12; i++) tick();
        check("br_pop0_pc", pop_pc[0], 32'h1F8);
        check("br_pop0_instr", pop_in[0], mem_word(32'h1F8));
        check("br_pop1_pc", pop_pc[1], 32'h1FC);

        // ---------------- redirect colliding with response and pop ----------------
        do_reset(2);
        for (int i = 0; i < 3; i++) tick();
        brTaken  = 1'b1;
        brPC     = 32'h300;
        brOffset = 32'h4;
        #1;
        check("col_out_valid", 32'(out_valid), 32'd0);
        tick();
        brTaken = 1'b0;
        #1;
        check("col_drop", 32'(dut.drop_q), 32'd1);
        check("col_count", 32'(dut.count_q), 32'd0);
        check("col_no_pop", 32'(pop_pc.size()), 32'd0);
        check("col_req_addr", imem_req_addr, 32'h310);
        for (int i = 0; i < 8; i++) tick();
        check("col_pop0_pc", pop_pc[0], 32'h310);

        // ---------------- freeze with 2 responses pending ----------------
        do_reset(3);
        tick();
        tick();
        freeze = 1'b1;
        #1;
        check("fz_req_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("fz_req_count", 32'(req_log.size()), 32'd2);
        check("fz_pop_count", 32'(pop_pc.size()), 32'd2);
        check("fz_pop1_pc", pop_pc[1], 32'h104);
        check("fz_fetch_pc", dut.fetch_pc_q, 32'h108);
        freeze = 1'b0;
        #1;
        check("fz_resume_valid", 32'(imem_req_valid), 32'd1);
        check("fz_resume_addr", imem_req_addr, 32'h108);

        // ---------------- PC wrap and mid-stream reset ----------------
        do_reset(1);
        brTaken  = 1'b1;
        brPC     = 32'hFFFF_FFF0;
        brOffset = 32'h3;
        tick();
        brTaken = 1'b0;
        #1;
        check("wr_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_req_addr1", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) tick();
        check("wr_pop0_pc", pop_pc[0], 32'hFFFF_FFFC);
        check("wr_pop1_pc", pop_pc[1], 32'h0000_0000);
        check("wr_pop1_instr", pop_in[1], mem_word(32'h0));
        rstn = 1'b0;
        tick();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_req_valid", 32'(imem_req_valid), 32'd0);
        check("mr_out_pc", out_pc, 32'd0);
        check("mr_out_instr", out_instr, 32'd0);
        check("mr_count", 32'(dut.count_q), 32'd0);
        rstn = 1'b1;
        #1;
        check("mr_restart_addr", imem_req_addr, 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
